// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the pipelined RV32I/RV64I immediate generator.
// Opcode-to-format classification lives here so every decoder agrees on it.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_UNK = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_e;

    function automatic fmt_e opcode_fmt(input logic [6:0] opcode);
        fmt_e f;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_FENCE: f = FMT_I;
            OP_STORE:                                      f = FMT_S;
            OP_BRANCH:                                     f = FMT_B;
            OP_LUI, OP_AUIPC:                              f = FMT_U;
            OP_JAL:                                        f = FMT_J;
            OP_REG:                                        f = FMT_R;
            default:                                       f = FMT_UNK;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction-word to {format, sign-extended immediate} decoder.
// R-format and unknown opcodes yield a zero immediate.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output fmt_e            fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32_s;

    // Assemble the 32-bit immediate, then sign-extend it to XLEN.
    always_comb begin
        fmt     = opcode_fmt(instr[6:0]);
        imm32_s = 32'd0;
        case (fmt)
            FMT_I:   imm32_s = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            FMT_U:   imm32_s = {instr[31:12], 12'd0};
            FMT_J:   imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0};
            default: imm32_s = 32'd0;
        endcase
        imm = XLEN'($signed(imm32_s));
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: input-side decode feeding a two-entry skid buffer
// with registered in_ready. Define IMM_GEN_ILLEGAL_EN to add the out_illegal flag.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [31:0]     out_instr
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    output logic            out_illegal
`endif
);

    fmt_e            dec_fmt_s;
    logic [XLEN-1:0] dec_imm_s;
    logic            accept_s;
    logic            take_s;

    skid_state_e     state_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [31:0]     m_instr_r;
    fmt_e            m_fmt_r;
    logic [XLEN-1:0] m_imm_r;
    logic [31:0]     k_instr_r;
    fmt_e            k_fmt_r;
    logic [XLEN-1:0] k_imm_r;
`ifdef IMM_GEN_ILLEGAL_EN
    logic            dec_ill_s;
    logic            m_ill_r;
    logic            k_ill_r;

    assign dec_ill_s   = (dec_fmt_s == FMT_UNK);
    assign out_illegal = m_ill_r;
`endif

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr (in_instr),
        .fmt   (dec_fmt_s),
        .imm   (dec_imm_s)
    );

    assign accept_s  = in_valid & in_ready_r;
    assign take_s    = out_valid_r & out_ready;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_imm   = m_imm_r;
    assign out_fmt   = m_fmt_r;
    assign out_instr = m_instr_r;

    // Skid FSM: M always drives the outputs, K only holds the word caught while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            m_instr_r   <= 32'd0;
            m_fmt_r     <= FMT_R;
            m_imm_r     <= '0;
            k_instr_r   <= 32'd0;
            k_fmt_r     <= FMT_R;
            k_imm_r     <= '0;
`ifdef IMM_GEN_ILLEGAL_EN
            m_ill_r     <= 1'b0;
            k_ill_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    in_ready_r <= 1'b1;
                    if (accept_s) begin
                        m_instr_r   <= in_instr;
                        m_fmt_r     <= dec_fmt_s;
                        m_imm_r     <= dec_imm_s;
`ifdef IMM_GEN_ILLEGAL_EN
                        m_ill_r     <= dec_ill_s;
`endif
                        out_valid_r <= 1'b1;
                        state_r     <= ST_FULL;
                    end else begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (take_s && accept_s) begin
                        m_instr_r <= in_instr;
                        m_fmt_r   <= dec_fmt_s;
                        m_imm_r   <= dec_imm_s;
`ifdef IMM_GEN_ILLEGAL_EN
                        m_ill_r   <= dec_ill_s;
`endif
                        state_r   <= ST_FULL;
                    end else if (take_s) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_EMPTY;
                    end else if (accept_s) begin
                        k_instr_r  <= in_instr;
                        k_fmt_r    <= dec_fmt_s;
                        k_imm_r    <= dec_imm_s;
`ifdef IMM_GEN_ILLEGAL_EN
                        k_ill_r    <= dec_ill_s;
`endif
                        in_ready_r <= 1'b0;
                        state_r    <= ST_SKID;
                    end else begin
                        state_r <= ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (take_s) begin
                        m_instr_r  <= k_instr_r;
                        m_fmt_r    <= k_fmt_r;
                        m_imm_r    <= k_imm_r;
`ifdef IMM_GEN_ILLEGAL_EN
                        m_ill_r    <= k_ill_r;
`endif
                        in_ready_r <= 1'b1;
                        state_r    <= ST_FULL;
                    end else begin
                        state_r <= ST_SKID;
                    end
                end
                default: begin
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    state_r     <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus;
// expected entries are queued on accept and popped by a monitor on each take.
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        lat;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        in_ready32, out_valid32, in_ready64, out_valid64;
    logic [31:0] out_imm32;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt32, out_fmt64;
    logic [31:0] out_instr32, out_instr64;
`ifdef IMM_GEN_ILLEGAL_EN
    logic        ill32, ill64;
`endif

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] cyc = 32'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_instr(out_instr32)
`ifdef IMM_GEN_ILLEGAL_EN
        , .out_illegal(ill32)
`endif
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_instr(out_instr64)
`ifdef IMM_GEN_ILLEGAL_EN
        , .out_illegal(ill64)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] w, input logic [2:0] f,
                        input logic [31:0] imm, input logic lat);
        int n = 0;
        in_valid = 1'b1;
        in_instr = w;
        while (!in_ready32 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready32) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            q.push_back({w, f, imm, lat, cyc});
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
    endtask

    // Monitor: compare both instances whenever a result is taken.
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid32 && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got instr %h, expected no output", out_instr32);
            end else begin
                mon_e = q.pop_front();
                chk("instr32", 64'(out_instr32), 64'(mon_e.instr));
                chk("fmt32", 64'(out_fmt32), 64'(mon_e.fmt));
                chk("imm32", 64'(out_imm32), 64'(mon_e.imm));
                chk("valid64", 64'(out_valid64), 64'd1);
                chk("instr64", 64'(out_instr64), 64'(mon_e.instr));
                chk("fmt64", 64'(out_fmt64), 64'(mon_e.fmt));
                chk("imm64", out_imm64, {{32{mon_e.imm[31]}}, mon_e.imm});
`ifdef IMM_GEN_ILLEGAL_EN
                chk("illegal32", 64'(ill32), 64'(mon_e.fmt == 3'd7));
                chk("illegal64", 64'(ill64), 64'(mon_e.fmt == 3'd7));
`endif
                if (mon_e.lat) chk("latency", 64'(cyc), 64'(mon_e.cyc + 32'd1));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected completion within 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid32), 64'd0);
        chk("rst_in_ready", 64'(in_ready32), 64'd0);
        chk("rst_imm", 64'(out_imm32), 64'd0);
        chk("rst_fmt", 64'(out_fmt32), 64'd0);
        chk("rst_instr", 64'(out_instr32), 64'd0);
        chk("rst_imm64", out_imm64, 64'd0);
`ifdef IMM_GEN_ILLEGAL_EN
        chk("rst_illegal", 64'(ill32), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 64'(in_ready32), 64'd1);

        // Back-to-back with out_ready=1: each result one cycle after accept.
        send(32'h4D202003, 3'd1, 32'h000004D2, 1'b1);
        send(32'hC0002C23, 3'd2, 32'hFFFFFC18, 1'b1);
        send(32'hC8000763, 3'd3, 32'hFFFFF48E, 1'b1);
        send(32'h123450B7, 3'd4, 32'h12345000, 1'b1);
        send(32'hFFDFF06F, 3'd5, 32'hFFFFFFFC, 1'b1);
        send(32'h00B50533, 3'd0, 32'h00000000, 1'b1);
        send(32'hFFF00013, 3'd1, 32'hFFFFFFFF, 1'b1);
        send(32'h800000B7, 3'd4, 32'h80000000, 1'b1);
        send(32'h0000007F, 3'd7, 32'h00000000, 1'b1);
        drain();

        // Backpressure: in_ready drops after two accepts, M holds the first word.
        out_ready = 1'b0;
        send(32'h00A00093, 3'd1, 32'h0000000A, 1'b0);
        send(32'h00112623, 3'd2, 32'h0000000C, 1'b0);
        chk("skid_in_ready", 64'(in_ready32), 64'd0);
        chk("skid_out_valid", 64'(out_valid32), 64'd1);
        chk("skid_hold_instr", 64'(out_instr32), 64'h00A00093);
        fork
            send(32'hFFF00067, 3'd1, 32'hFFFFFFFF, 1'b0);
            begin
                repeat (2) @(negedge clk);
                chk("stall_hold_instr", 64'(out_instr32), 64'h00A00093);
                chk("stall_hold_imm", 64'(out_imm32), 64'h0000000A);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset while in SKID: both entries discarded.
        out_ready = 1'b0;
        send(32'h00000013, 3'd1, 32'h00000000, 1'b0);
        send(32'h00C00023, 3'd2, 32'h00000000, 1'b0);
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid32), 64'd0);
        chk("midrst_in_ready", 64'(in_ready32), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        send(32'h00000073, 3'd1, 32'h00000000, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the RV32I/RV64I decode path. Accepts raw instruction words over a valid/ready handshake, classifies the encoding format, and emits the sign-extended immediate one cycle later. A two-entry skid buffer keeps `in_ready` registered, so the block can sit between fetch and decode without a combinational ready path.

## Interface
- `XLEN`, default 32: immediate output width; legal values are 32 and 64; sign extension fills up to `XLEN`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  instruction word present.
- `in_ready`  out  1  block can accept; registered.
- `in_instr`  in  32  raw instruction.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result.
- `out_imm`  out  XLEN  sign-extended immediate.
- `out_fmt`  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, UNK=7.
- `out_instr`  out  32  instruction passthrough, aligned with `out_imm`.
- `out_illegal`  out  1  unknown opcode flag; present only with `IMM_GEN_ILLEGAL_EN`.

## Operation
- Decode uses `opcode = instr[6:0]`.
  - I-format: 0000011, 0010011, 1100111, 1110011, 0001111.
  - S-format: 0100011.
  - B-format: 1100011.
  - U-format: 0110111, 0010111.
  - J-format: 1101111.
  - R-format: 0110011; immediate is 0.
  - Any other opcode: UNK; immediate is 0.
- Immediate assembly (bit 31 is the sign bit throughout):
  - I: `instr[31:20]`.
  - S: `{instr[31:25], instr[11:7]}`.
  - B: `{instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}`.
  - U: `{instr[31:12], 12'b0}`.
  - J: `{instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}`.
  - All formats are sign-extended from `instr[31]` to `XLEN`.
- OP-IMM shift encodings use plain I-format extension; the ALU masks the shift amount.
- Storage: main register M (drives outputs) and skid register K. State machine:
  - EMPTY: `out_valid=0`, `in_ready=1`. An accept loads M and moves to FULL.
  - FULL: `out_valid=1`, `in_ready=1`.
    - Output taken and new input accepted: reload M, stay FULL.
    - Output taken, no input: go to EMPTY.
    - Input accepted, output not taken: load K, go to SKID.
  - SKID: `out_valid=1`, `in_ready=0`. When the output is taken, move K into M and go to FULL.
- Accept = `in_valid & in_ready`. Take = `out_valid & out_ready`.
- While `out_valid=1` and `out_ready=0`, `out_*` must hold stable.

## Timing
- Latency: an instruction accepted on edge N appears on `out_*` after edge N, that is, in cycle N+1.
- Throughput: one result per cycle while `out_ready=1`.
- Reset values, all outputs:
  - `out_valid=0`, `in_ready=0` during reset; `in_ready=1` from the first cycle after `rst_n` rises.
  - `out_imm=0`, `out_fmt=0`, `out_instr=0`, `out_illegal=0`.
- Reset mid-operation: entries in M and K are discarded and no stale result is emitted.
- In SKID, `in_valid` is ignored and the upstream source must hold its data.
- Simultaneous accept and take in FULL is lossless: M is replaced by the new word in the same edge.

## Configuration
- `IMM_GEN_ILLEGAL_EN` defined: `out_illegal` is present and equals `(out_fmt==UNK)`. It is registered alongside M/K.
- `IMM_GEN_ILLEGAL_EN` undefined: the port and its flop are removed. UNK still reports `out_fmt=7` and `out_imm=0`.

## Structure
- Shared package `imm_gen_pkg`:
  - format enum (R, I, S, B, U, J, UNK).
  - opcode constants (OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_FENCE, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG).
  - skid state enum (EMPTY, FULL, SKID).
- One sub-module, `imm_decode`: purely combinational instr → {fmt, imm}. It is instantiated once, on the input side.
- The top level holds only the skid/handshake logic.

## Test plan
- `out_ready=1`, XLEN=32. Send the following back-to-back:
  - 0x4D202003 (lw) → imm 0x000004D2, fmt I.
  - 0xC0002C23 (sw) → imm 0xFFFFFC18, fmt S.
  - 0xC8000763 (beq) → imm 0xFFFFF48E, fmt B.
  - Results appear one per cycle in order, each one cycle after its accept.
- 0x123450B7 (lui) → 0x12345000, fmt U. 0xFFDFF06F (jal) → 0xFFFFFFFC, fmt J. 0x00B50533 (add) → imm 0, fmt R.
- XLEN=64: 0xFFF00013 (addi -1) → 0xFFFFFFFFFFFFFFFF. 0x800000B7 → 0xFFFFFFFF80000000.
- Backpressure: hold `out_ready=0` and push 3 words.
  - `in_ready` drops after the 2nd accept; `out_*` holds the first word.
  - Release `out_ready`: all 3 words drain in order, none lost or duplicated.
- Reset mid-stream: assert `rst_n=0` while in SKID → `out_valid=0` after the edge, and the next accepted word is the first output.
- 0x0000007F → fmt 7, imm 0. With `IMM_GEN_ILLEGAL_EN`, `out_illegal=1`; it is 0 for every legal case above.
